// File: rtl/fpu_addsub_pipe.sv
// Three-stage pipelined IEEE-style adder/subtractor with flush-to-zero for subnormals.
// Define FPU_ADDSUB_RNE_EN for round-to-nearest-even; otherwise results truncate toward zero.
module fpu_addsub_pipe #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic                     op_sub,
   input  logic [EXP_W+MAN_W:0]     a,
   input  logic [EXP_W+MAN_W:0]     b,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [EXP_W+MAN_W:0]     result,
   output logic [3:0]               flags
);
   localparam int W  = 1 + EXP_W + MAN_W;
   localparam int XW = MAN_W + 4;   // hidden, mantissa, guard, round, sticky
   localparam int AW = MAN_W + 3;   // hidden, mantissa, guard, round
   localparam logic [EXP_W-1:0] EXP_MAX = '1;

   typedef struct packed {
      logic             valid;
      logic             special;
      logic [W-1:0]     spec_res;
      logic [3:0]       spec_flags;
      logic             sign;
      logic             eff_sub;
      logic [EXP_W-1:0] expo;
      logic [XW-1:0]    sig_l;
      logic [XW-1:0]    sig_s;
   } s1_t;

   typedef struct packed {
      logic             valid;
      logic             special;
      logic [W-1:0]     spec_res;
      logic [3:0]       spec_flags;
      logic             sign;
      logic             eff_sub;
      logic [EXP_W-1:0] expo;
      logic [XW:0]      sum;
   } s2_t;

   typedef struct packed {
      logic         valid;
      logic [W-1:0] res;
      logic [3:0]   flg;
   } s3_t;

   s1_t s1_q, s1_d, s1_n;
   s2_t s2_q, s2_d;
   s3_t s3_q, s3_d;

   logic advance;
   assign advance   = !(s3_q.valid && !out_ready);
   assign in_ready  = advance;
   assign out_valid = s3_q.valid;
   assign result    = s3_q.res;
   assign flags     = s3_q.flg;

   // S1: classify, order by magnitude, align the smaller operand
   logic             sa, sb, sl, swap;
   logic [EXP_W-1:0] ea, eb, el, es;
   logic             a_nan, b_nan, a_inf, b_inf, a_snan, b_snan;
   logic [W-2:0]     mag_a, mag_b, mag_l, mag_s;
   logic [MAN_W:0]   hl, hs;
   logic [31:0]      diff, sh;
   logic [2*AW-1:0]  algn;
   logic [W-1:0]     qnan;

   always_comb begin
      qnan   = {1'b0, EXP_MAX, 1'b1, {(MAN_W-1){1'b0}}};
      sa     = a[W-1];
      sb     = b[W-1] ^ op_sub;
      ea     = a[W-2:MAN_W];
      eb     = b[W-2:MAN_W];
      a_nan  = (ea == EXP_MAX) && (a[MAN_W-1:0] != '0);
      b_nan  = (eb == EXP_MAX) && (b[MAN_W-1:0] != '0);
      a_inf  = (ea == EXP_MAX) && (a[MAN_W-1:0] == '0);
      b_inf  = (eb == EXP_MAX) && (b[MAN_W-1:0] == '0);
      a_snan = a_nan && !a[MAN_W-1];
      b_snan = b_nan && !b[MAN_W-1];
      mag_a  = (ea == '0) ? '0 : a[W-2:0];
      mag_b  = (eb == '0) ? '0 : b[W-2:0];
      swap   = mag_b > mag_a;
      sl     = swap ? sb : sa;
      mag_l  = swap ? mag_b : mag_a;
      mag_s  = swap ? mag_a : mag_b;
      el     = mag_l[W-2:MAN_W];
      es     = mag_s[W-2:MAN_W];
      hl     = (el == '0) ? '0 : {1'b1, mag_l[MAN_W-1:0]};
      hs     = (es == '0) ? '0 : {1'b1, mag_s[MAN_W-1:0]};
      diff   = 32'(el) - 32'(es);
      sh     = (diff >= 32'(AW)) ? 32'(AW) : diff;
      // lower half collects everything shifted past the round bit
      algn   = {hs, 2'b00, {AW{1'b0}}} >> sh;

      s1_n            = '0;
      s1_n.valid      = in_valid;
      s1_n.sign       = sl;
      s1_n.eff_sub    = sa ^ sb;
      s1_n.expo       = el;
      s1_n.sig_l      = {hl, 3'b000};
      s1_n.sig_s      = {algn[2*AW-1:AW], |algn[AW-1:0]};
      s1_n.special    = a_nan || b_nan || a_inf || b_inf;
      if (a_nan || b_nan) begin
         s1_n.spec_res   = qnan;
         s1_n.spec_flags = {a_snan || b_snan, 3'b000};
      end else if (a_inf && b_inf && (sa != sb)) begin
         s1_n.spec_res   = qnan;
         s1_n.spec_flags = 4'b1000;
      end else if (a_inf) begin
         s1_n.spec_res   = {sa, EXP_MAX, {MAN_W{1'b0}}};
      end else if (b_inf) begin
         s1_n.spec_res   = {sb, EXP_MAX, {MAN_W{1'b0}}};
      end
      s1_d = advance ? s1_n : s1_q;
   end

   // S2: magnitude add/subtract; larger-first ordering keeps the difference non-negative
   always_comb begin
      s2_d = s2_q;
      if (advance) begin
         s2_d.valid      = s1_q.valid;
         s2_d.special    = s1_q.special;
         s2_d.spec_res   = s1_q.spec_res;
         s2_d.spec_flags = s1_q.spec_flags;
         s2_d.sign       = s1_q.sign;
         s2_d.eff_sub    = s1_q.eff_sub;
         s2_d.expo       = s1_q.expo;
         s2_d.sum        = s1_q.eff_sub ? ({1'b0, s1_q.sig_l} - {1'b0, s1_q.sig_s})
                                        : ({1'b0, s1_q.sig_l} + {1'b0, s1_q.sig_s});
      end
   end

   // S3: normalise, round, pack
   logic [7:0]          lzc;
   logic                found, g, r, st, inexact, rnd_up;
   logic [XW-1:0]       norm;
   logic [MAN_W-1:0]    mant;
   logic [MAN_W:0]      mant_r;
   logic signed [15:0]  exp_n, exp_r;
   logic [W-1:0]        res;
   logic [3:0]          flg;

   always_comb begin
      lzc   = 8'd0;
      found = 1'b0;
      for (int i = XW-1; i >= 0; i--) begin
         if (!found) begin
            if (s2_q.sum[i]) found = 1'b1;
            else             lzc   = lzc + 8'd1;
         end
      end
      if (s2_q.sum[XW]) begin
         norm  = {s2_q.sum[XW:2], s2_q.sum[1] | s2_q.sum[0]};
         exp_n = $signed(16'(s2_q.expo)) + 16'sd1;
      end else begin
         norm  = s2_q.sum[XW-1:0] << lzc;
         exp_n = $signed(16'(s2_q.expo)) - $signed(16'(lzc));
      end
      mant    = norm[XW-2:3];
      g       = norm[2];
      r       = norm[1];
      st      = norm[0];
      inexact = g | r | st;
`ifdef FPU_ADDSUB_RNE_EN
      rnd_up  = g & (r | st | mant[0]);
`else
      rnd_up  = 1'b0;
`endif
      mant_r  = {1'b0, mant} + {{MAN_W{1'b0}}, rnd_up};
      exp_r   = exp_n + (mant_r[MAN_W] ? 16'sd1 : 16'sd0);

      res = {s2_q.sign, exp_r[EXP_W-1:0], mant_r[MAN_W-1:0]};
      flg = {3'b000, inexact};
      if (s2_q.special) begin
         res = s2_q.spec_res;
         flg = s2_q.spec_flags;
      end else if (s2_q.sum == '0) begin
         res = {s2_q.eff_sub ? 1'b0 : s2_q.sign, {(W-1){1'b0}}};
         flg = 4'b0000;
      end else if (exp_n <= 16'sd0) begin
         res = {s2_q.sign, {(W-1){1'b0}}};
         flg = 4'b0011;
      end else if (exp_r >= $signed(16'(EXP_MAX))) begin
`ifdef FPU_ADDSUB_RNE_EN
         res = {s2_q.sign, EXP_MAX, {MAN_W{1'b0}}};
`else
         res = {s2_q.sign, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
`endif
         flg = 4'b0101;
      end

      s3_d = s3_q;
      if (advance) begin
         s3_d.valid = s2_q.valid;
         s3_d.res   = res;
         s3_d.flg   = flg;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_q <= '0;
         s2_q <= '0;
         s3_q <= '0;
      end else begin
         s1_q <= s1_d;
         s2_q <= s2_d;
         s3_q <= s3_d;
      end
   end

endmodule

// File: doc/fpu_addsub_pipe.md
FPU_ADDSUB_PIPE -- requirements
Module: fpu_addsub_pipe

Interface
REQ-001 Parameter EXP_W, default 8, exponent field width in bits (legal range 4..11).
REQ-002 Parameter MAN_W, default 23, stored mantissa field width in bits (legal range 4..52); word width W = 1+EXP_W+MAN_W.
REQ-003 Port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port in_valid  input  1  operand pair presented.
REQ-006 Port in_ready  output  1  block accepts operands this cycle.
REQ-007 Port op_sub  input  1  1 computes a-b, 0 computes a+b.
REQ-008 Port a  input  W  first IEEE-format operand.
REQ-009 Port b  input  W  second IEEE-format operand.
REQ-010 Port out_valid  output  1  result presented.
REQ-011 Port out_ready  input  1  consumer accepts result this cycle.
REQ-012 Port result  output  W  IEEE-format sum/difference.
REQ-013 Port flags  output  4  {invalid, overflow, underflow, inexact} for the presented result.

Function
REQ-014 Transfer in occurs when in_valid and in_ready are both 1; transfer out occurs when out_valid and out_ready are both 1.
REQ-015 Three-stage pipeline: S1 unpack, classify, swap so the larger magnitude is first, align the smaller with guard, round and sticky bits; S2 add or subtract the magnitudes (effective operation = op_sub XOR sign(a) XOR sign(b)); S3 leading-zero normalise, round, pack, flag.
REQ-016 Latency shall be exactly 3 cycles from transfer in to out_valid when no stall occurs; throughput shall be one operation per cycle.
REQ-017 Stall: when out_valid=1 and out_ready=0, all stages shall hold and in_ready shall be 0; otherwise in_ready shall be 1, including when the pipeline is full and out_ready=1.
REQ-018 Each stage shall carry a valid bit; bubbles shall propagate and never assert out_valid.
REQ-019 result and flags shall be stable while out_valid=1 and out_ready=0.
REQ-020 Subnormal inputs shall be treated as zero (sign kept); subnormal results shall flush to signed zero with underflow=1 and inexact=1.
REQ-021 The sticky bit shall be the OR of all bits shifted past the round bit; an alignment shift of MAN_W+3 or more shall leave only sticky.
REQ-022 An exact zero from an effective subtraction shall return +0; (-0)+(-0) shall return -0.
REQ-023 Any NaN operand, or inf minus inf, shall return canonical qNaN (sign 0, exponent all ones, mantissa MSB only); invalid=1 only for inf-inf or a signalling-NaN operand.
REQ-024 inf combined with a finite operand shall return that inf, with no flags set.
REQ-025 A rounded exponent of all ones or above shall return a signed infinity with overflow=1 and inexact=1.
REQ-026 A mantissa carry-out during rounding shall increment the exponent and re-check overflow.

Reset
REQ-027 While reset=1: all stage valid bits, out_valid, result and flags shall be 0, and in_ready shall be 1.
REQ-028 Reset asserted mid-operation shall discard all in-flight operations with no result delivered; the first operation after release shall complete with normal 3-cycle latency.

Configuration
REQ-029 Macro FPU_ADDSUB_RNE_EN defined: S3 shall round to nearest, ties to even, using guard, round and sticky bits.
REQ-030 Macro FPU_ADDSUB_RNE_EN undefined: S3 shall truncate (round toward zero); overflow shall return the largest finite value of the result's sign instead of infinity; inexact shall still report discarded bits.

Verification
REQ-031 Defaults, out_ready=1: a=0x3F800000, b=0x3F800000, op_sub=0 -> after 3 cycles result=0x40000000, flags=0000.
REQ-032 a=0x3F800000, b=0x33800000 (2^-24, a tie) -> RNE: result=0x3F800000, inexact=1; with a=0x3F800001 -> result=0x3F800002.
REQ-033 a=0x7F800000, b=0x7F800000, op_sub=1 -> result=0x7FC00000, invalid=1; a=0x7F7FFFFF twice, op_sub=0 -> 0x7F800000, overflow=1 and inexact=1 (0x7F7FFFFF when the macro is undefined).
REQ-034 Back-to-back stream of 8 operations with out_ready held 0 for cycles 4-6 -> in_ready=0 in those cycles, no result lost or duplicated, results delivered in order.
REQ-035 a=0x3F800000, b=0x3F800000, op_sub=1 -> result=0x00000000; a=0x80000000, b=0x80000000, op_sub=0 -> 0x80000000.
REQ-036 Reset pulsed with 2 operations in flight -> out_valid=0 through the reset and until a new operation completes 3 cycles after its transfer in.
